wb_master_port: RTL

Wishbone initiator that converts a simple valid/ready request/response interface into classic single-transfer Wishbone cycles, with one transaction outstanding. It sits between a requester (core load/store unit, debug bridge, DMA sequencer) and any Wishbone slave in the memory subsystem, e.g. the block-RAM slaves. A bounded ack timeout guarantees forward progress: a slave that never acks produces an error response instead of hanging the requester.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wishbone_if.sv | 28 ++
 rtl/wb_timeout_counter.sv | 32 +++
 rtl/wb_master_port.sv | 123 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: response record and default timeout.
package wb_pkg;

  localparam int WB_DATA_WIDTH      = 32;
  localparam int WB_DEFAULT_TIMEOUT = 16;

  // Response returned to the requester. The rdata field is sized by
  // WB_DATA_WIDTH, so a port instance must use that data width.
  typedef struct packed {
    logic [WB_DATA_WIDTH-1:0] rdata;
    logic                     err;
  } wb_rsp_t;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone signal bundle. dat_o is initiator-to-target write data,
// dat_i is target-to-initiator read data.
interface wishbone_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
) ();

  logic                    rst_i;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    ack;

  modport master (
    input  rst_i, ack, dat_i,
    output cyc, stb, we, adr, dat_o, sel
  );

  modport slave (
    input  rst_i, cyc, stb, we, adr, dat_o, sel,
    output ack, dat_i
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Counts bus-wait cycles and flags the cycle in which the wait budget ends.
module wb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count_q;

  // Cycle counter; clear has priority over enable.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order.
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The first bus cycle sees count 0, so TIMEOUT-1 marks the last one.
  assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_port.sv
// Valid/ready request/response to single-transfer Wishbone initiator with
// one transaction outstanding and a bounded ack timeout.
module wb_master_port
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int TIMEOUT    = WB_DEFAULT_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  wishbone_if.master              wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  wb_rsp_t                 rsp_q;

  logic accept;
  logic finish;
  logic in_bus;
  logic expired;

  assign in_bus = (state_q == ST_BUS);

  // Next-state decode and handshake strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb.ack || expired) begin
          finish  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, request holding registers and response capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q  <= req_we_i;
        adr_q <= req_addr_i;
        dat_q <= req_wdata_i;
        sel_q <= req_sel_i;
      end
      // Ack wins over a simultaneous timeout; writes and errors return 0.
      if (finish) begin
        rsp_q.rdata <= (wb.ack && !we_q) ? wb.dat_i : '0;
        rsp_q.err   <= !wb.ack;
      end
    end
  end

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (!in_bus || finish),
    .enable  (in_bus),
    .expired (expired)
  );

  // Bus controls decode from the state register only; adr/dat_o hold.
  assign wb.cyc   = in_bus;
  assign wb.stb   = in_bus;
  assign wb.we    = in_bus && we_q;
  assign wb.sel   = in_bus ? sel_q : '0;
  assign wb.adr   = adr_q;
  assign wb.dat_o = dat_q;

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

endmodule
